// File: rtl/fpnew_divsqrt_th_ctrl.sv
// Valid/ready sequencing for the iterative div/sqrt datapath: drives the input and
// output stage enables, the start pulse, and carries tag/aux for the in-flight op.
module fpnew_divsqrt_th_ctrl #(
    parameter int unsigned NumInpRegs = 0,
    parameter int unsigned NumOutRegs = 0,
    parameter int unsigned TagWidth   = 1,
    parameter int unsigned AuxWidth   = 1,
    localparam int unsigned EnW = ((NumInpRegs + NumOutRegs) > 0) ? (NumInpRegs + NumOutRegs) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [TagWidth-1:0] in_tag_i,
    input  logic [AuxWidth-1:0] in_aux_i,
    input  logic                flush_i,
    output logic [EnW-1:0]      reg_enable_o,
    output logic                fsm_start_o,
    input  logic                fsm_ready_i,
    input  logic                unit_done_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [TagWidth-1:0] out_tag_o,
    output logic [AuxWidth-1:0] out_aux_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e              state_q;
    logic [TagWidth-1:0] fsm_tag_q;
    logic [AuxWidth-1:0] fsm_aux_q;
    logic                acc;

    logic [NumInpRegs:0] in_vld;
    logic [NumInpRegs:0] in_rdy;
    logic [TagWidth-1:0] in_tag [NumInpRegs+1];
    logic [AuxWidth-1:0] in_aux [NumInpRegs+1];

    logic [NumOutRegs:0] out_vld;
    logic [NumOutRegs:0] out_rdy;
    logic [TagWidth-1:0] out_tag [NumOutRegs+1];
    logic [AuxWidth-1:0] out_aux [NumOutRegs+1];

    // Reset gating keeps in_ready_o and the start pulse low while rst_ni is asserted.
    assign acc = rst_ni & (state_q == IDLE) & fsm_ready_i & ~flush_i;

    assign in_vld[0]          = in_valid_i;
    assign in_tag[0]          = in_tag_i;
    assign in_aux[0]          = in_aux_i;
    assign in_rdy[NumInpRegs] = acc;
    assign in_ready_o         = in_rdy[0];
    assign fsm_start_o        = in_vld[NumInpRegs] & acc;

    if ((NumInpRegs + NumOutRegs) == 0) begin : g_no_regs
        assign reg_enable_o = 1'b0;
    end

    // ---- input stages ----
    for (genvar i = 0; i < NumInpRegs; i++) begin : g_inp
        // Closed-form ready: stage i can advance if any later stage has a hole or the FSM accepts.
        assign in_rdy[i]       = acc | (rst_ni & ~flush_i & ~(&in_vld[NumInpRegs:i+1]));
        assign reg_enable_o[i] = in_vld[i] & in_rdy[i];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                in_vld[i+1] <= 1'b0;
                in_tag[i+1] <= '0;
                in_aux[i+1] <= '0;
            end else begin
                if (flush_i) begin
                    in_vld[i+1] <= 1'b0;
                end else if (in_rdy[i]) begin
                    in_vld[i+1] <= in_vld[i];
                end
                if (reg_enable_o[i]) begin
                    in_tag[i+1] <= in_tag[i];
                    in_aux[i+1] <= in_aux[i];
                end
            end
        end
    end

    // ---- FSM ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            fsm_tag_q <= '0;
            fsm_aux_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fsm_start_o) begin
                        state_q   <= BUSY;
                        fsm_tag_q <= in_tag[NumInpRegs];
                        fsm_aux_q <= in_aux[NumInpRegs];
                    end
                end
                BUSY: begin
                    if (unit_done_i) state_q <= out_rdy[0] ? IDLE : HOLD;
                end
                HOLD: begin
                    if (out_rdy[0]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Done seen in IDLE/HOLD belongs to a flushed op and never reaches the output pipe.
    assign out_vld[0]          = rst_ni & ~flush_i &
                                 (((state_q == BUSY) & unit_done_i) | (state_q == HOLD));
    assign out_tag[0]          = fsm_tag_q;
    assign out_aux[0]          = fsm_aux_q;
    assign out_rdy[NumOutRegs] = out_ready_i;

    // ---- output stages ----
    for (genvar j = 0; j < NumOutRegs; j++) begin : g_out
        assign out_rdy[j]                   = ~flush_i & (out_ready_i | ~(&out_vld[NumOutRegs:j+1]));
        assign reg_enable_o[NumInpRegs + j] = out_vld[j] & out_rdy[j];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_vld[j+1] <= 1'b0;
                out_tag[j+1] <= '0;
                out_aux[j+1] <= '0;
            end else begin
                if (flush_i) begin
                    out_vld[j+1] <= 1'b0;
                end else if (out_rdy[j]) begin
                    out_vld[j+1] <= out_vld[j];
                end
                if (reg_enable_o[NumInpRegs + j]) begin
                    out_tag[j+1] <= out_tag[j];
                    out_aux[j+1] <= out_aux[j];
                end
            end
        end
    end

    assign out_valid_o = out_vld[NumOutRegs];
    assign out_tag_o   = out_tag[NumOutRegs];
    assign out_aux_o   = out_aux[NumOutRegs];

    assign busy_o = (|(in_vld >> 1)) | (|(out_vld >> 1)) | (state_q != IDLE);

endmodule
